sm_mac_accumulator: RTL and testbench
=====================================

SM_MAC_ACCUMULATOR -- requirements
Module: sm_mac_accumulator

Interface
REQ-001 SHALL have parameter N, default 4, operand width in sign-magnitude format (MSB sign, N-1 magnitude bits).
REQ-002 SHALL have parameter M, default 2*N, accumulator width in sign-magnitude format (MSB sign, M-1 magnitude bits).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port a  input  N  multiplicand, sign-magnitude.
REQ-008 SHALL have port b  input  N  multiplier, sign-magnitude.
REQ-009 SHALL have port clear  input  1  zero the accumulator and overflow flag.
REQ-010 SHALL have port out_valid  output  1  acc holds a new accumulated result.
REQ-011 SHALL have port out_ready  input  1  downstream consumes result.
REQ-012 SHALL have port acc  output  M  accumulator register, sign-magnitude, always visible.
REQ-013 SHALL have port overflow  output  1  sticky accumulation-overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, ACC, OUT; in_ready = 1 only in IDLE; out_valid = 1 only in OUT.
REQ-015 IDLE: on in_valid=1, SHALL latch a, b, clear the partial product and bit counter, then go to MUL.
REQ-016 MUL: SHALL do shift-add over the N-1 magnitude bits of b, one bit per cycle, exactly N-1 cycles, then go to ACC.
REQ-017 Product sign SHALL be a[N-1] XOR b[N-1], forced to 0 when product magnitude is 0 (no -0).
REQ-018 Product magnitude (at most 2N-2 bits) SHALL be zero-extended to M-1 bits without loss.
REQ-019 ACC: SHALL add the product to acc in one cycle, then go to OUT.
- same signs: add magnitudes, keep sign.
- different signs: subtract smaller magnitude from larger; result takes the sign of the larger.
- equal magnitudes: +0 (0...0).
REQ-020 A same-sign carry out of bit M-2 SHALL set overflow; result per REQ-031.
REQ-021 OUT: SHALL hold out_valid=1 and acc stable until out_ready=1, then go to IDLE on that edge.
REQ-022 Latency: out_valid SHALL rise exactly N+1 cycles after the in_valid/in_ready accept edge when out_ready is held 1. Throughput is one operation per N+2 cycles.
REQ-023 clear SHALL act only in IDLE and zero acc and overflow; it is ignored in MUL, ACC and OUT.
REQ-024 clear with in_valid in the same IDLE cycle SHALL apply clear first, so the result equals the new product alone.
REQ-025 Input -0 (sign 1, magnitude 0) SHALL be treated as +0.
REQ-026 a/b changes outside the accept edge SHALL have no effect.

Reset
REQ-027 Reset SHALL force IDLE, acc=0, overflow=0, out_valid=0, in_ready=1, and clear the counter and partial product, immediately and asynchronously.
REQ-028 Reset in any state, including mid-MUL, SHALL abort the operation; the pending product is discarded.
REQ-029 The first accept after reset is allowed on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro SM_MAC_SATURATE_EN SHALL select overflow handling.
REQ-031 With SM_MAC_SATURATE_EN defined, overflow SHALL saturate acc to the maximum magnitude (all M-1 bits 1) with the operand sign. Without it, the magnitude SHALL wrap modulo 2^(M-1) with the operand sign. The overflow flag is set in both builds.

Verification (N=4, M=8)
REQ-032 Reset, then a=0011 (+3), b=1010 (-2) -> out_valid after 5 cycles, acc=1000_0110 (-6), overflow=0.
REQ-033 Following REQ-032, a=0111, b=0111 (+49) -> acc=0010_1011 (+43); then a=1011 (-3), b=0000 -> acc stays 0010_1011, with no -0 product effect.
REQ-034 clear+in_valid together with a=0111, b=0111, then +49 twice more -> acc 0011_0001, then 0110_0010, then on the third operation overflow=1 and acc=0111_1111 with SATURATE_EN or 0001_0011 without it.
REQ-035 acc=+6 (0000_0110), then a=1011, b=0010 (-6) -> acc=0000_0000, never 1000_0000.
REQ-036 Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, acc stable, in_ready=0, and in_valid is ignored; out_ready=1 -> IDLE next cycle.
REQ-037 Assert reset during the 2nd MUL cycle -> all outputs take reset values immediately; after release a new operation completes correctly from acc=0.

Source files
------------

// File: rtl/sm_mac_accumulator.sv
// Sign-magnitude multiply-accumulate unit.
// A serial shift-add multiplier forms |a|*|b| over N-1 cycles. The product is then
// added into a sign-magnitude accumulator that is held until the result is consumed.
// Optional build macro: SM_MAC_SATURATE_EN. When it is defined, an accumulation overflow
// saturates the magnitude; otherwise the magnitude wraps. The overflow flag is sticky
// in both builds.
module sm_mac_accumulator #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 2 * N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         clear,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] acc,
    output logic         overflow
);

    localparam int unsigned PW   = 2 * N - 2;  // full product magnitude width
    localparam int unsigned MW   = M - 1;      // accumulator magnitude width
    localparam int unsigned CW   = (N > 2) ? $clog2(N - 1) : 1;
    localparam logic [CW-1:0] LastBit = CW'(N - 2);

    typedef enum logic [1:0] {StIdle, StMul, StAcc, StOut} state_e;

    state_e          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   pp;
    logic [PW-1:0]   a_sh;
    logic [N-2:0]    b_sh;
    logic            p_sign;

    logic [MW-1:0]   prod_mag;
    logic [MW-1:0]   acc_mag;
    logic [MW-1:0]   res_mag;
    logic [MW:0]     sum;
    logic            prod_sign;
    logic            res_sign;
    logic            ovf_set;
    logic [M-1:0]    acc_nxt;

    // Sign-magnitude add of the finished product into the accumulator
    always_comb begin
        prod_mag  = MW'(pp);
        // A zero product is +0 whatever the operand signs (covers -0 inputs too)
        prod_sign = p_sign & (pp != '0);
        acc_mag   = acc[M-2:0];
        sum       = {1'b0, acc_mag} + {1'b0, prod_mag};
        ovf_set   = 1'b0;
        res_sign  = acc[M-1];
        res_mag   = acc_mag;
        if (prod_sign == acc[M-1]) begin
            res_sign = prod_sign;
            if (sum[MW]) begin
                ovf_set = 1'b1;
`ifdef SM_MAC_SATURATE_EN
                res_mag = '1;
`else
                res_mag = sum[MW-1:0];
`endif
            end else begin
                res_mag = sum[MW-1:0];
            end
        end else if (acc_mag > prod_mag) begin
            res_mag  = acc_mag - prod_mag;
            res_sign = acc[M-1];
        end else if (prod_mag > acc_mag) begin
            res_mag  = prod_mag - acc_mag;
            res_sign = prod_sign;
        end else begin
            res_mag  = '0;
            res_sign = 1'b0;
        end
        // Never leave -0 in the accumulator
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        acc_nxt = {res_sign, res_mag};
    end

    // Control FSM, serial multiplier datapath and registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            overflow  <= 1'b0;
            cnt       <= '0;
            pp        <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            p_sign    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (clear) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                    if (in_valid) begin
                        a_sh     <= PW'(a[N-2:0]);
                        b_sh     <= b[N-2:0];
                        p_sign   <= a[N-1] ^ b[N-1];
                        pp       <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= StMul;
                    end
                end
                StMul: begin
                    if (b_sh[0]) begin
                        pp <= pp + a_sh;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LastBit) begin
                        state <= StAcc;
                    end
                end
                StAcc: begin
                    acc       <= acc_nxt;
                    if (ovf_set) begin
                        overflow <= 1'b1;
                    end
                    out_valid <= 1'b1;
                    state     <= StOut;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_mac_accumulator.sv
// Directed bench for sm_mac_accumulator (N=4, M=8) with hand-computed expectations.
module tb_sm_mac_accumulator;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    sm_mac_accumulator #(.N(4), .M(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full operation with out_ready held high; checks latency, result and return to idle.
    // Operands and clear are scrambled while the operation is in flight.
    task automatic do_op(input string tag, input logic [3:0] oa, input logic [3:0] ob,
                         input logic clr, input logic [7:0] exp_acc, input logic exp_ovf);
        int cyc;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        a = oa; b = ob; in_valid = 1'b1; clear = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b1; a = ~oa; b = ~ob;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        clear = 1'b0;
        check({tag, "_lat"}, 32'(cyc), 32'd5);
        check({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; clear = 1'b0; out_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_ov", 32'(out_valid), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // +3 * -2 = -6
        do_op("m1", 4'b0011, 4'b1010, 1'b0, 8'h86, 1'b0);
        // -6 + 49 = +43
        do_op("m2", 4'b0111, 4'b0111, 1'b0, 8'h2B, 1'b0);
        // -3 * 0 is +0, accumulator unchanged
        do_op("m3", 4'b1011, 4'b0000, 1'b0, 8'h2B, 1'b0);
        // clear with in_valid, then accumulate 49 three times
        do_op("c1", 4'b0111, 4'b0111, 1'b1, 8'h31, 1'b0);
        do_op("c2", 4'b0111, 4'b0111, 1'b0, 8'h62, 1'b0);
`ifdef SM_MAC_SATURATE_EN
        do_op("c3", 4'b0111, 4'b0111, 1'b0, 8'h7F, 1'b1);
`else
        do_op("c3", 4'b0111, 4'b0111, 1'b0, 8'h13, 1'b1);
`endif

        // clear alone in idle zeroes acc and the sticky flag
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr_acc", 32'(acc), 32'd0);
        check("clr_ovf", 32'(overflow), 32'd0);

        // +6 then -6 gives +0, not -0
        do_op("z1", 4'b0011, 4'b0010, 1'b0, 8'h06, 1'b0);
        do_op("z2", 4'b1011, 4'b0010, 1'b0, 8'h00, 1'b0);

        // Backpressure: +2 * +3 = +6 held in OUT for 5 cycles
        out_ready = 1'b0;
        @(negedge clk);
        a = 4'b0010; b = 4'b0011; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 4'b0111; b = 4'b0111; clear = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_ov0", 32'(out_valid), 32'd1);
        check("bp_acc0", 32'(acc), 32'h06);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_ov%0d", i + 1), 32'(out_valid), 32'd1);
            check($sformatf("bp_acc%0d", i + 1), 32'(acc), 32'h06);
            check($sformatf("bp_rdy%0d", i + 1), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_rdy", 32'(in_ready), 32'd1);
        check("bp_idle_ov", 32'(out_valid), 32'd0);
        check("bp_acc_kept", 32'(acc), 32'h06);
        @(posedge clk);
        #1;
        check("bp_no_accept", 32'(in_ready), 32'd1);

        // Reset during the second MUL cycle
        @(negedge clk);
        a = 4'b0111; b = 4'b0111; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mr_rdy", 32'(in_ready), 32'd1);
        check("mr_ov", 32'(out_valid), 32'd0);
        check("mr_acc", 32'(acc), 32'd0);
        check("mr_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // +3 * -3 = -9 from a zero accumulator
        do_op("r1", 4'b0011, 4'b1011, 1'b0, 8'h89, 1'b0);
        // -0 operand: product is +0, accumulator unchanged
        do_op("r2", 4'b1000, 4'b0101, 1'b0, 8'h89, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
